// File: rtl/pulse_rate_counter.sv
// Pulse rate counter: edge-detects a pulse stream, applies a detector dead time and
// reports the number of accepted events per fixed gate window with valid/ack handshake.
module pulse_rate_counter #(
    parameter int GATE_CYCLES = 1000,
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic             enable,
    input  logic             count_ack,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             count_sat,
    output logic             overrun,
    output logic             dead_active
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX   = '1;
    localparam logic [DW-1:0]    DEAD_LOAD = (DEAD_CYCLES > 0) ? DW'(DEAD_CYCLES - 1) : '0;

    typedef enum logic {IDLE, DEAD} state_t;

    state_t           state, state_next;
    logic [DW-1:0]    dead_cnt, dead_cnt_next;
    logic             pulse_q;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] acc, acc_inc;
    logic             sat, sat_inc;
    logic             rise, accept, eow;

    assign rise    = pulse & ~pulse_q;
    assign accept  = enable & rise & (state == IDLE);
    assign eow     = enable & (gate_cnt == GATE_LAST);
    // Accumulator and sat flag as they stand after this cycle's event, if any.
    assign acc_inc = (accept && acc != ACC_MAX) ? acc + 1'b1 : acc;
    assign sat_inc = sat | (accept & (acc == ACC_MAX));

    assign dead_active = (state == DEAD);

    // dead_cnt holds the number of DEAD cycles still to follow the current one.
    always_comb begin
        state_next    = state;
        dead_cnt_next = dead_cnt;
        if (!enable) begin
            state_next    = IDLE;
            dead_cnt_next = '0;
        end else begin
            case (state)
                IDLE: if (accept && DEAD_CYCLES > 0) begin
                    state_next    = DEAD;
                    dead_cnt_next = DEAD_LOAD;
                end
                DEAD: if (dead_cnt == '0) state_next = IDLE;
                      else dead_cnt_next = dead_cnt - 1'b1;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and every
    // register here uses non-blocking assignment to avoid ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dead_cnt <= '0;
        end else begin
            state    <= state_next;
            dead_cnt <= dead_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_q     <= 1'b0;
            gate_cnt    <= '0;
            acc         <= '0;
            sat         <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            count_sat   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pulse_q <= pulse;

            if (!enable || eow) begin
                gate_cnt <= '0;
                acc      <= '0;
                sat      <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                acc      <= acc_inc;
                sat      <= sat_inc;
            end

            // A coinciding ack consumes the old result; the new one stays valid.
            if (eow) begin
                count       <= acc_inc;
                count_sat   <= sat_inc;
                count_valid <= 1'b1;
                if (count_valid && !count_ack) overrun <= 1'b1;
                else if (count_ack)            overrun <= 1'b0;
            end else if (count_ack && count_valid) begin
                count_valid <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Self-checking bench: two parameterisations driven by shared stimulus, compared every
// cycle against an event-counting reference model, plus directed literal expectations.
module tb_pulse_rate_counter;

    logic       clk = 1'b0;
    logic       rst_n, pulse, enable, count_ack;
    logic [3:0] a_count;
    logic       a_valid, a_sat, a_over, a_dead;
    logic [2:0] b_count;
    logic       b_valid, b_sat, b_over, b_dead;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    pulse_rate_counter #(.GATE_CYCLES(16), .DEAD_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .enable(enable), .count_ack(count_ack),
        .count(a_count), .count_valid(a_valid), .count_sat(a_sat), .overrun(a_over),
        .dead_active(a_dead));

    pulse_rate_counter #(.GATE_CYCLES(16), .DEAD_CYCLES(0), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .enable(enable), .count_ack(count_ack),
        .count(b_count), .count_valid(b_valid), .count_sat(b_sat), .overrun(b_over),
        .dead_active(b_dead));

    // Reference: events are counted as an unbounded integer and clipped only on report.
    typedef struct {
        int prev; int dead_left; int pos; int events;
        int count; int valid; int sat; int overrun;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic mdl_t step(mdl_t m, int dead, int gate, int w,
                                  logic rst, logic p, logic en, logic ack);
        mdl_t n;
        int   max_v, ev;
        bit   edge_seen, accepted;
        n     = m;
        max_v = (1 << w) - 1;
        if (!rst) begin
            n = '{0, 0, 0, 0, 0, 0, 0, 0};
            return n;
        end
        edge_seen = (p == 1'b1) && (m.prev == 0);
        n.prev    = int'(p);
        if (!en) begin
            n.dead_left = 0; n.pos = 0; n.events = 0;
            if (ack && m.valid == 1) begin n.valid = 0; n.overrun = 0; end
            return n;
        end
        accepted = edge_seen && (m.dead_left == 0);
        if (accepted && dead > 0) n.dead_left = dead;
        else if (m.dead_left > 0) n.dead_left = m.dead_left - 1;
        ev = m.events + (accepted ? 1 : 0);
        if (m.pos == gate - 1) begin
            n.count  = (ev > max_v) ? max_v : ev;
            n.sat    = (ev > max_v) ? 1 : 0;
            n.events = 0;
            n.pos    = 0;
            n.valid  = 1;
            if (m.valid == 1 && !ack) n.overrun = 1;
            else if (ack)             n.overrun = 0;
        end else begin
            n.pos    = m.pos + 1;
            n.events = ev;
            if (ack && m.valid == 1) begin n.valid = 0; n.overrun = 0; end
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_a = step(m_a, 2, 16, 4, rst_n, pulse, enable, count_ack);
        m_b = step(m_b, 0, 16, 3, rst_n, pulse, enable, count_ack);
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("a.count",   int'(a_count), m_a.count);
            check("a.valid",   int'(a_valid), m_a.valid);
            check("a.sat",     int'(a_sat),   m_a.sat);
            check("a.overrun", int'(a_over),  m_a.overrun);
            check("a.dead",    int'(a_dead),  (m_a.dead_left > 0) ? 1 : 0);
            check("b.count",   int'(b_count), m_b.count);
            check("b.valid",   int'(b_valid), m_b.valid);
            check("b.sat",     int'(b_sat),   m_b.sat);
            check("b.overrun", int'(b_over),  m_b.overrun);
            check("b.dead",    int'(b_dead),  (m_b.dead_left > 0) ? 1 : 0);
        end
    end

    // Inputs change right after a falling edge; the call returns at the next falling edge.
    task automatic drive(input logic p, input logic en, input logic ack, input logic r);
        pulse = p; enable = en; count_ack = ack; rst_n = r;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; pulse = 1'b0; enable = 1'b0; count_ack = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("lit.reset.count", int'(a_count), 0);
        check("lit.reset.valid", int'(a_valid), 0);

        // Window A: single-cycle pulses at 1, 5, 9.
        for (int i = 0; i < 16; i++) drive(i == 1 || i == 5 || i == 9, 1, 0, 1);
        check("lit.A.count", int'(a_count), 3);
        check("lit.A.valid", int'(a_valid), 1);
        check("lit.A.sat",   int'(a_sat),   0);

        // Window B: pulse high 3..4, low 5, high 6; dead time covers cycles 4 and 5.
        for (int i = 0; i < 16; i++) begin
            drive(i == 3 || i == 4 || i == 6, 1, 0, 1);
            if (i == 2) check("lit.B.dead2", int'(a_dead), 0);
            if (i == 3) check("lit.B.dead4", int'(a_dead), 1);
            if (i == 4) check("lit.B.dead5", int'(a_dead), 1);
            if (i == 5) check("lit.B.dead6", int'(a_dead), 0);
        end
        check("lit.B.count",   int'(a_count), 2);
        check("lit.B.overrun", int'(a_over),  1);

        // Window C: toggle every other cycle, ack exactly on end-of-window.
        for (int i = 0; i < 16; i++) drive(i % 2 == 0, 1, i == 15, 1);
        check("lit.C.a_count", int'(a_count), 4);
        check("lit.C.b_count", int'(b_count), 7);
        check("lit.C.b_sat",   int'(b_sat),   1);
        check("lit.C.valid",   int'(a_valid), 1);
        check("lit.C.overrun", int'(a_over),  0);

        // Window D: ack in cycle 0, events at 1 and 5, enable dropped at 8 for 3 cycles.
        drive(0, 1, 1, 1);
        check("lit.D.ack_valid", int'(a_valid), 0);
        for (int i = 1; i < 8; i++) drive(i == 1 || i == 5, 1, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
        check("lit.D.hold_count", int'(a_count), 4);
        check("lit.D.hold_valid", int'(a_valid), 0);
        for (int i = 0; i < 16; i++) drive(i == 2 || i == 10, 1, 0, 1);
        check("lit.D.count", int'(a_count), 2);
        check("lit.D.valid", int'(a_valid), 1);

        // Window E: event at 9, reset during dead time at cycle 10.
        for (int i = 0; i < 10; i++) drive(i == 9, 1, 0, 1);
        check("lit.E.dead", int'(a_dead), 1);
        drive(0, 1, 0, 0);
        check("lit.E.rst_count", int'(a_count), 0);
        check("lit.E.rst_valid", int'(a_valid), 0);
        check("lit.E.rst_dead",  int'(a_dead),  0);
        check("lit.E.rst_over",  int'(a_over),  0);

        // Window F: full window after reset; event on end-of-window cycle is included.
        for (int i = 0; i < 15; i++) drive(0, 1, 0, 1);
        check("lit.F.not_yet", int'(a_valid), 0);
        drive(1, 1, 0, 1);
        check("lit.F.count", int'(a_count), 1);
        check("lit.F.valid", int'(a_valid), 1);

        // Randomised traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 19) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 499) != 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_rate_counter.md
PULSE_RATE_COUNTER -- requirements
Module: pulse_rate_counter

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 1000, meaning the measurement window length in clk cycles (>=2).
REQ-002 The block SHALL have parameter DEAD_CYCLES, default 4, meaning the detector dead time in clk cycles after an accepted event (0 = none).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the count accumulator and result width.
REQ-004 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  reset; synchronous, active-low.
REQ-006 Port pulse  input  1  raw pulse stream from the upstream random pulse generator, synchronous to clk.
REQ-007 Port enable  input  1  measurement enable; 0 holds gate, accumulator and dead-time logic cleared.
REQ-008 Port count_ack  input  1  consumer acknowledge of the current result.
REQ-009 Port count  output  CNT_W  events counted in the last completed window.
REQ-010 Port count_valid  output  1  count holds an unacknowledged result.
REQ-011 Port count_sat  output  1  accumulator saturated during the window reported in count.
REQ-012 Port overrun  output  1  a result was overwritten before being acknowledged.
REQ-013 Port dead_active  output  1  dead-time window in progress.

Function
REQ-014 The block SHALL register pulse into pulse_q every cycle (also while enable=0); a rising edge SHALL be pulse=1 and pulse_q=0 in the same cycle; a pulse held high for N cycles SHALL be one edge.
REQ-015 The dead-time FSM SHALL have states IDLE and DEAD; a rising edge in IDLE with enable=1 SHALL be an accepted event.
REQ-016 An event accepted in cycle t SHALL move the FSM to DEAD for cycles t+1..t+DEAD_CYCLES, then IDLE; edges in DEAD SHALL be dropped and SHALL NOT extend dead time; with DEAD_CYCLES=0 the FSM SHALL remain IDLE.
REQ-017 dead_active SHALL be 1 exactly when the FSM is in DEAD.
REQ-018 While enable=1 the gate counter SHALL count 0..GATE_CYCLES-1 and wrap to 0.
REQ-019 The accumulator SHALL increment by 1 per accepted event, saturating at 2^CNT_W-1; a sat flag SHALL set on any increment attempted at the maximum.
REQ-020 In the cycle the gate counter equals GATE_CYCLES-1 (end-of-window), the next edge SHALL load count with the accumulator value including any event accepted that cycle, load count_sat with the sat flag (including that cycle), set count_valid=1, and clear accumulator and sat flag to 0.
REQ-021 count, count_sat SHALL hold between end-of-window loads.
REQ-022 count_ack=1 while count_valid=1 SHALL clear count_valid and overrun on the next edge; count_ack while count_valid=0 SHALL have no effect.
REQ-023 End-of-window while count_valid=1 and count_ack=0 SHALL overwrite count/count_sat and set overrun=1 (sticky until ack).
REQ-024 End-of-window coinciding with count_ack SHALL load the new result, keep count_valid=1 and leave overrun=0.
REQ-025 enable=0 SHALL on the next edge clear gate counter, accumulator, sat flag and force FSM to IDLE; count, count_valid, count_sat, overrun SHALL hold and ack SHALL still be honoured.
REQ-026 Deasserting enable mid-window SHALL discard the partial window; reassertion SHALL start a full GATE_CYCLES window at gate counter 0.

Reset
REQ-027 rst_n=0 at a rising clk edge SHALL set count=0, count_valid=0, count_sat=0, overrun=0, dead_active=0, pulse_q=0, gate counter=0, accumulator=0, sat flag=0, FSM=IDLE.
REQ-028 Reset mid-window or mid-dead-time SHALL discard all partial state; the first window after release SHALL be a full GATE_CYCLES window.

Verification (GATE_CYCLES=16, DEAD_CYCLES=2, CNT_W=4 unless stated)
REQ-029 Single-cycle pulses at window cycles 1, 5, 9, no ack -> count=3, count_valid=1, count_sat=0 one edge after window cycle 15.
REQ-030 Pulses at cycles 3, 4 (held high), 5 (new edge after low? none), 6 -> pulse high 3..4, low 5, high 6: edge 3 accepted, edge 6 accepted (DEAD covers 4..5), count=2; edge at 4 with pulse low at 3 would be dropped -> dead_active high exactly cycles 4,5.
REQ-031 Pulse toggling every other cycle, DEAD_CYCLES=0 -> 8 edges in window -> count=8; with CNT_W=3 -> count=7, count_sat=1.
REQ-032 Two consecutive windows, no ack -> second result overwrites, overrun=1; ack -> count_valid=0, overrun=0 next edge; ack exactly on end-of-window edge -> count_valid stays 1, overrun=0.
REQ-033 enable dropped at window cycle 8 with 2 events counted, raised 3 cycles later -> partial discarded, next result reflects only events in the new 16-cycle window; prior count unchanged meanwhile.
REQ-034 rst_n low for 1 cycle during DEAD at cycle 10 -> all outputs 0, dead_active=0 next edge, next window full 16 cycles.
